cv32e40p_rf_wb_arbiter: RTL
===========================

# cv32e40p_rf_wb_arbiter

Writeback arbiter and pending-write scoreboard in front of the two-write-port register file. It steers three writeback requesters onto write ports A and B: ALU/EX, LSU and APU/FPU. It resolves port-B contention between LSU and APU round-robin, and defers same-address collisions. It also tracks registers with outstanding APU results so decode can stall on them.

## Interface
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32, register data width.
- clk_int  in  1  gated core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid_i / ex_addr_i / ex_data_i  in  1/ADDR_WIDTH/DATA_WIDTH  ALU writeback request; always accepted.
- lsu_valid_i / lsu_addr_i / lsu_data_i  in  1/ADDR_WIDTH/DATA_WIDTH  load writeback request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- apu_valid_i / apu_addr_i / apu_data_i  in  1/ADDR_WIDTH/DATA_WIDTH  APU writeback request.
- apu_ready_o  out  1  APU request accepted this cycle.
- apu_issue_i / apu_issue_addr_i  in  1/ADDR_WIDTH  APU op issued with destination register.
- waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1  register-file write port A.
- waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1  register-file write port B.
- busy_o  out  2**ADDR_WIDTH  pending-APU-write bitmask, one bit per register.

## Operation
- Port A is owned by EX: we_a_o = ex_valid_i, with address and data passed through. EX is never stalled.
- Port B serves LSU or APU:
  - If only one is valid, it is granted.
  - If both are valid, the round-robin pointer decides. Pointer value 0 favours LSU; value 1 favours APU.
  - After a port-B grant to X, the pointer moves to favour the other requester.
  - The loser sees ready=0 and must hold its valid, address and data stable.
- Collision: if a port-B candidate address equals ex_addr_i and ex_valid_i=1, port B is not granted that cycle.
  - Both LSU and APU ready are deasserted; we_b_o=0.
  - The pointer is unchanged.
- Register x0: address 6'd0 with bank bit 0 is accepted (ready=1) but the matching we_*_o is forced 0. FP f0 (6'd32) is written normally.
- Idle outputs: when we_*_o=0, waddr/wdata outputs are driven 0.
- Scoreboard:
  - apu_issue_i sets busy_o[apu_issue_addr_i].
  - An accepted APU writeback (apu_valid_i & apu_ready_o) clears busy_o[apu_addr_i].
  - Set and clear on the same address in the same cycle: set wins.
  - Issue to x0 never sets the bit.

## Timing
- Grant path is combinational, with zero latency from valid inputs to ready and write-port outputs.
- The round-robin pointer and scoreboard update on posedge clk_int.
- busy_o reflects an issue one cycle after apu_issue_i.
- The clear is visible the cycle after the accepted writeback. The register file's own write latency is separate.
- Reset values: pointer=0 (LSU favoured), busy_o=0. lsu_ready_o, apu_ready_o, we_a_o and we_b_o follow their inputs combinationally and are 0 when all valids are 0.
- Reset asserted mid-operation clears pointer and scoreboard immediately. Pending APU results are then untracked by design; the core flushes the APU on reset.
- Because clk_int is gated, the state changes only on cycles where the clock runs. The integration keeps clk_int enabled whenever lsu_valid_i, apu_valid_i or apu_issue_i is high.

## Configuration
- CV32E40P_WB_SCOREBOARD_EN defined: the scoreboard is built as described above.
- Not defined: no scoreboard flops; busy_o is tied to 0. Decode must then stall on the APU by a different means. Arbitration is unchanged.

## Test plan
- Reset, then LSU-only write of 0xDEADBEEF to x5 → we_b_o=1, waddr_b_o=5, lsu_ready_o=1, pointer flips to favour APU.
- LSU (x6) and APU (f3 = 6'd35) valid together for 3 cycles with LSU held → grants LSU, APU, LSU in order, one per cycle.
- EX writes x7 while LSU also targets x7 → we_a_o=1, we_b_o=0, lsu_ready_o=0. The next cycle, with EX idle, LSU is granted.
- LSU writeback to x0 → lsu_ready_o=1, we_b_o=0. APU writeback to f0 (6'd32) → we_b_o=1.
- apu_issue_i to f4, then busy_o[36]=1 for 4 cycles, then an accepted APU write to f4 → bit clears the next cycle. A same-cycle new issue to f4 keeps it set.
- Assert rst_n low while busy_o≠0 and the pointer favours APU → busy_o=0 and the pointer favours LSU immediately, without waiting for a clock.

Source files
------------

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Writeback arbiter and APU pending-write scoreboard for the two-port RF.
// Define CV32E40P_WB_SCOREBOARD_EN to build the scoreboard; otherwise busy_o=0.
module cv32e40p_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk_int,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    input  logic [ADDR_WIDTH-1:0]    ex_addr_i,
    input  logic [DATA_WIDTH-1:0]    ex_data_i,
    input  logic                     lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]    lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]    lsu_data_i,
    output logic                     lsu_ready_o,
    input  logic                     apu_valid_i,
    input  logic [ADDR_WIDTH-1:0]    apu_addr_i,
    input  logic [DATA_WIDTH-1:0]    apu_data_i,
    output logic                     apu_ready_o,
    input  logic                     apu_issue_i,
    input  logic [ADDR_WIDTH-1:0]    apu_issue_addr_i,
    output logic [ADDR_WIDTH-1:0]    waddr_a_o,
    output logic [DATA_WIDTH-1:0]    wdata_a_o,
    output logic                     we_a_o,
    output logic [ADDR_WIDTH-1:0]    waddr_b_o,
    output logic [DATA_WIDTH-1:0]    wdata_b_o,
    output logic                     we_b_o,
    output logic [2**ADDR_WIDTH-1:0] busy_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic                  rr_q, rr_d;
    logic                  pick_lsu, pick_apu;
    logic                  coll;
    logic                  gnt_lsu, gnt_apu;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic [DATA_WIDTH-1:0] cand_data;

    always_comb begin
        pick_lsu  = lsu_valid_i & (~apu_valid_i | ~rr_q);
        pick_apu  = apu_valid_i & ~pick_lsu;
        cand_addr = pick_lsu ? lsu_addr_i : apu_addr_i;
        cand_data = pick_lsu ? lsu_data_i : apu_data_i;
        coll      = ex_valid_i & (pick_lsu | pick_apu) &
                    (cand_addr == ex_addr_i);
        gnt_lsu   = pick_lsu & ~coll;
        gnt_apu   = pick_apu & ~coll;
    end

    assign lsu_ready_o = gnt_lsu;
    assign apu_ready_o = gnt_apu;

    // x0 (integer bank, bank bit clear) is accepted but never written
    always_comb begin
        we_a_o    = ex_valid_i & (ex_addr_i != '0);
        waddr_a_o = we_a_o ? ex_addr_i : '0;
        wdata_a_o = we_a_o ? ex_data_i : '0;
        we_b_o    = (gnt_lsu | gnt_apu) & (cand_addr != '0);
        waddr_b_o = we_b_o ? cand_addr : '0;
        wdata_b_o = we_b_o ? cand_data : '0;
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_lsu) begin
            rr_d = 1'b1;
        end else if (gnt_apu) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef CV32E40P_WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    // set is applied after clear so a same-cycle reissue keeps the bit
    always_comb begin
        busy_d = busy_q;
        if (gnt_apu) begin
            busy_d[apu_addr_i] = 1'b0;
        end
        if (apu_issue_i && (apu_issue_addr_i != '0)) begin
            busy_d[apu_issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{apu_issue_i, apu_issue_addr_i};
    assign busy_o       = {NREG{1'b0}};
`endif

endmodule
